// File: rtl/div_unit_if.sv
// Request/result bundle between the EX stage and the iterative divider.
// The pipeline drives the master side; div_unit sits on the slave side.
interface div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic             signed_i;
  logic [WIDTH-1:0] dividend_i;
  logic [WIDTH-1:0] divisor_i;
  logic             abort_i;
  logic             div_stall_o;
  logic             done_o;
  logic [WIDTH-1:0] quotient_o;
  logic [WIDTH-1:0] remainder_o;
  logic             busy_o;

  modport master (
    output start_i, signed_i, dividend_i, divisor_i, abort_i,
    input  div_stall_o, done_o, quotient_o, remainder_o, busy_o
  );

  modport slave (
    input  start_i, signed_i, dividend_i, divisor_i, abort_i,
    output div_stall_o, done_o, quotient_o, remainder_o, busy_o
  );
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring divider for MIPS DIV/DIVU: one quotient bit per cycle on
// operand magnitudes, sign fix-up at the end; quotient goes to LO, remainder to HI.
module div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic      clk_i,
  input  logic      rst_i,
  div_unit_if.slave div_bus
);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PREP = 3'd1;
  localparam logic [2:0] S_ITER = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]       r_state;
  logic [WIDTH-1:0] r_dividend;
  logic [WIDTH-1:0] r_divisor;
  logic             r_signed;
  logic             r_sign_dvd;
  logic             r_sign_dvs;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH:0]   r_dvs_mag;
  logic [CNT_W-1:0] r_cnt;
  logic             r_dz;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;

  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dvs_mag;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH:0]   w_trial;
  logic             w_trial_neg;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;

  // Negating 0x80000000 wraps to itself, which is the correct unsigned magnitude.
  assign w_dvd_mag   = (r_signed && r_sign_dvd) ? -r_dividend : r_dividend;
  assign w_dvs_mag   = (r_signed && r_sign_dvs) ? -r_divisor  : r_divisor;
  assign w_rem_sh    = {r_rem, r_q[WIDTH-1]};
  assign w_trial     = w_rem_sh - r_dvs_mag;
  assign w_trial_neg = w_trial[WIDTH];
  assign w_q_fix     = r_dz ? {WIDTH{1'b1}} :
                       (r_signed && (r_sign_dvd ^ r_sign_dvs)) ? -r_q : r_q;
  assign w_r_fix     = r_dz ? r_dividend :
                       (r_signed && r_sign_dvd) ? -r_rem : r_rem;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_dividend  <= '0;
      r_divisor   <= '0;
      r_signed    <= 1'b0;
      r_sign_dvd  <= 1'b0;
      r_sign_dvs  <= 1'b0;
      r_rem       <= '0;
      r_q         <= '0;
      r_dvs_mag   <= '0;
      r_cnt       <= '0;
      r_dz        <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (div_bus.start_i) begin
            r_dividend <= div_bus.dividend_i;
            r_divisor  <= div_bus.divisor_i;
            r_signed   <= div_bus.signed_i;
            r_sign_dvd <= div_bus.dividend_i[WIDTH-1];
            r_sign_dvs <= div_bus.divisor_i[WIDTH-1];
            r_state    <= S_PREP;
          end
        end
        S_PREP: begin
          if (div_bus.abort_i) begin
            r_state <= S_IDLE;
          end else begin
            r_rem     <= '0;
            r_q       <= w_dvd_mag;
            r_dvs_mag <= {1'b0, w_dvs_mag};
            r_cnt     <= CNT_W'(WIDTH - 1);
            r_dz      <= (r_divisor == '0);
            r_state   <= S_ITER;
          end
        end
        S_ITER: begin
          if (div_bus.abort_i) begin
            r_state <= S_IDLE;
          end else begin
            r_rem <= w_trial_neg ? w_rem_sh[WIDTH-1:0] : w_trial[WIDTH-1:0];
            r_q   <= {r_q[WIDTH-2:0], ~w_trial_neg};
            if (r_cnt == '0) begin
              r_state <= S_FIX;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
        end
        S_FIX: begin
          if (div_bus.abort_i) begin
            r_state <= S_IDLE;
          end else begin
            r_quotient  <= w_q_fix;
            r_remainder <= w_r_fix;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign div_bus.div_stall_o = (r_state == S_PREP) || (r_state == S_ITER) || (r_state == S_FIX);
  assign div_bus.done_o      = (r_state == S_DONE);
  assign div_bus.busy_o      = (r_state != S_IDLE);
  assign div_bus.quotient_o  = r_quotient;
  assign div_bus.remainder_o = r_remainder;
endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed cases plus randomized back-to-back
// DIV/DIVU operations checked against an arithmetic reference model.
module tb_div_unit;
  localparam int WIDTH = 32;

  logic clk_i = 1'b0;
  logic rst_i;
  int   checkCount = 0;
  int   passCount  = 0;

  always #5 clk_i = ~clk_i;

  div_unit_if #(.WIDTH(WIDTH)) bus ();

  div_unit #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .div_bus (bus)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    else
      passCount++;
  endtask

  // Reference result {quotient, remainder} from plain 64-bit arithmetic.
  function automatic logic [63:0] refModel(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return {32'hFFFF_FFFF, a};
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {q[31:0], r[31:0]};
  endfunction

  function automatic logic [31:0] randOperand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 15));
      default: return 32'($urandom);
    endcase
  endfunction

  // Issues one operation from the IDLE cycle following the current negedge and
  // follows it to the done cycle; optionally injects a stray start mid-flight.
  task automatic applyStimulus(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                               input int injectCycle, input logic abortWithStart, input string tag);
    logic [63:0] expRes;
    int stallErr, stallCnt, doneCnt, doneCyc;
    expRes = refModel(sgn, a, b);
    @(negedge clk_i);
    bus.start_i    = 1'b1;
    bus.signed_i   = sgn;
    bus.dividend_i = a;
    bus.divisor_i  = b;
    bus.abort_i    = abortWithStart;
    @(posedge clk_i);
    stallErr = 0; stallCnt = 0; doneCnt = 0; doneCyc = 0;
    for (int cyc = 1; cyc <= WIDTH + 3; cyc++) begin
      @(negedge clk_i);
      if (cyc == 1) begin
        bus.start_i = 1'b0;
        bus.abort_i = 1'b0;
      end
      if (injectCycle != 0 && cyc == injectCycle) begin
        bus.start_i    = 1'b1;
        bus.signed_i   = ~sgn;
        bus.dividend_i = ~a;
        bus.divisor_i  = b + 32'd3;
      end
      if (injectCycle != 0 && cyc == injectCycle + 1) bus.start_i = 1'b0;
      if (bus.div_stall_o !== (cyc <= WIDTH + 2)) stallErr++;
      if (bus.div_stall_o === 1'b1) stallCnt++;
      if (bus.done_o === 1'b1) begin
        doneCnt++;
        doneCyc = cyc;
      end
    end
    checkOutput({tag, " stallPattern"}, 32'(stallErr), 32'd0);
    checkOutput({tag, " stallCount"}, 32'(stallCnt), 32'(WIDTH + 2));
    checkOutput({tag, " doneCount"}, 32'(doneCnt), 32'd1);
    checkOutput({tag, " doneCycle"}, 32'(doneCyc), 32'(WIDTH + 3));
    checkOutput({tag, " quotient"}, bus.quotient_o, expRes[63:32]);
    checkOutput({tag, " remainder"}, bus.remainder_o, expRes[31:0]);
  endtask

  initial begin
    int doneSeen;
    logic sgn;
    logic [31:0] a, b;

    rst_i          = 1'b1;
    bus.start_i    = 1'b0;
    bus.signed_i   = 1'b0;
    bus.dividend_i = '0;
    bus.divisor_i  = '0;
    bus.abort_i    = 1'b0;
    repeat (2) @(negedge clk_i);
    checkOutput("reset quotient", bus.quotient_o, 32'd0);
    checkOutput("reset remainder", bus.remainder_o, 32'd0);
    checkOutput("reset stall", 32'(bus.div_stall_o), 32'd0);
    checkOutput("reset done", 32'(bus.done_o), 32'd0);
    checkOutput("reset busy", 32'(bus.busy_o), 32'd0);
    rst_i = 1'b0;

    // Basic unsigned divide, then results must hold once idle.
    applyStimulus(1'b0, 32'd100, 32'd7, 0, 1'b0, "divu 100/7");
    @(negedge clk_i);
    checkOutput("hold quotient", bus.quotient_o, 32'd14);
    checkOutput("hold remainder", bus.remainder_o, 32'd2);
    checkOutput("hold done", 32'(bus.done_o), 32'd0);
    checkOutput("hold busy", 32'(bus.busy_o), 32'd0);

    applyStimulus(1'b1, 32'hFFFF_FFF9, 32'd2, 0, 1'b0, "div -7/2");
    applyStimulus(1'b1, 32'd7, 32'hFFFF_FFFE, 0, 1'b0, "div 7/-2");
    applyStimulus(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0, "div overflow");
    applyStimulus(1'b0, 32'h0000_1234, 32'd0, 0, 1'b0, "divu by zero");
    applyStimulus(1'b1, 32'hFFFF_FFFB, 32'd0, 0, 1'b0, "div by zero");

    // Abort mid-iteration leaves the previous result visible.
    applyStimulus(1'b0, 32'hFFFF_FFFF, 32'd1, 0, 1'b0, "abort opA");
    @(negedge clk_i);
    bus.start_i    = 1'b1;
    bus.signed_i   = 1'b0;
    bus.dividend_i = 32'd999;
    bus.divisor_i  = 32'd4;
    @(posedge clk_i);
    doneSeen = 0;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk_i);
      if (cyc == 1) bus.start_i = 1'b0;
      if (cyc == 10) bus.abort_i = 1'b1;
      if (bus.done_o === 1'b1) doneSeen++;
    end
    @(negedge clk_i);
    bus.abort_i = 1'b0;
    checkOutput("abort stall", 32'(bus.div_stall_o), 32'd0);
    checkOutput("abort busy", 32'(bus.busy_o), 32'd0);
    checkOutput("abort done", 32'(bus.done_o | (doneSeen != 0)), 32'd0);
    checkOutput("abort quotient", bus.quotient_o, 32'hFFFF_FFFF);
    checkOutput("abort remainder", bus.remainder_o, 32'd0);
    applyStimulus(1'b0, 32'd1000, 32'd33, 0, 1'b0, "after abort");
    applyStimulus(1'b1, 32'hFFFF_FF00, 32'd9, 0, 1'b1, "start with abort");

    // Reset in the middle of an operation: everything clears, no done follows.
    @(negedge clk_i);
    bus.start_i    = 1'b1;
    bus.signed_i   = 1'b1;
    bus.dividend_i = 32'd12345;
    bus.divisor_i  = 32'd7;
    @(posedge clk_i);
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk_i);
      if (cyc == 1) bus.start_i = 1'b0;
      if (cyc == 20) rst_i = 1'b1;
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    checkOutput("midreset quotient", bus.quotient_o, 32'd0);
    checkOutput("midreset remainder", bus.remainder_o, 32'd0);
    checkOutput("midreset stall", 32'(bus.div_stall_o), 32'd0);
    checkOutput("midreset busy", 32'(bus.busy_o), 32'd0);
    doneSeen = 0;
    for (int cyc = 0; cyc < WIDTH + 4; cyc++) begin
      @(negedge clk_i);
      if (bus.done_o === 1'b1) doneSeen++;
    end
    checkOutput("midreset no done", 32'(doneSeen), 32'd0);

    applyStimulus(1'b0, 32'd5000, 32'd13, 10, 1'b0, "ignored start");

    // Randomized back-to-back operations.
    for (int n = 0; n < 1000; n++) begin
      sgn = 1'($urandom_range(0, 1));
      a   = randOperand();
      b   = randOperand();
      applyStimulus(sgn, a, b, 0, 1'b0, $sformatf("rand%0d %s %h/%h", n, sgn ? "div" : "divu", a, b));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
